// File: rtl/sram_arbiter_pkg.sv
// Shared definitions for the two-master SRAM-bus arbiter: master IDs,
// transfer size encodings and the request payload carried toward the slave.
package sram_arbiter_pkg;

   localparam logic MST_INST = 1'b0;
   localparam logic MST_DATA = 1'b1;

   localparam logic [1:0] SIZE_1B = 2'd0;
   localparam logic [1:0] SIZE_2B = 2'd1;
   localparam logic [1:0] SIZE_4B = 2'd2;

   localparam int SRAM_PAYLOAD_W = 1 + 2 + 32 + 4 + 32;

   typedef struct packed {
      logic        wr;
      logic [1:0]  size;
      logic [31:0] addr;
      logic [3:0]  wstrb;
      logic [31:0] wdata;
   } sram_payload_t;

endpackage

// File: rtl/arb_owner_fifo.sv
// In-order FIFO of 1-bit master IDs, one entry per request the slave has
// accepted but not yet answered. The head names the owner of the next data_ok.
module arb_owner_fifo #(
   parameter int DEPTH = 4
) (
   input  logic                     clk,
   input  logic                     resetn,
   input  logic                     push,
   input  logic                     push_id,
   input  logic                     pop,
   output logic [$clog2(DEPTH):0]   count,
   output logic                     head,
   output logic                     empty,
   output logic                     full
);

   localparam int PW = $clog2(DEPTH);
   localparam logic [PW-1:0] PTR_ONE  = PW'(1);
   localparam logic [PW:0]   CNT_ONE  = (PW+1)'(1);
   localparam logic [PW:0]   CNT_FULL = (PW+1)'(DEPTH);

   logic          mem [DEPTH];
   logic [PW-1:0] wr_ptr;
   logic [PW-1:0] rd_ptr;
   logic          do_push;
   logic          do_pop;

   assign empty   = (count == '0);
   assign full    = (count == CNT_FULL);
   assign do_push = push & ~full;
   assign do_pop  = pop & ~empty;
   assign head    = mem[rd_ptr];

   // Pointers wrap naturally because DEPTH is a power of two; a simultaneous
   // push and pop leaves the count unchanged.
   always_ff @(posedge clk or negedge resetn) begin
      if (!resetn) begin
         wr_ptr <= '0;
         rd_ptr <= '0;
         count  <= '0;
         for (int i = 0; i < DEPTH; i++) mem[i] <= 1'b0;
      end else begin
         if (do_push) begin
            mem[wr_ptr] <= push_id;
            wr_ptr      <= wr_ptr + PTR_ONE;
         end
         if (do_pop) rd_ptr <= rd_ptr + PTR_ONE;
         case ({do_push, do_pop})
            2'b10:   count <= count + CNT_ONE;
            2'b01:   count <= count - CNT_ONE;
            default: count <= count;
         endcase
      end
   end

endmodule

// File: rtl/sram_arbiter.sv
// Shares one SRAM-like slave bus between instruction fetch (m0) and the data
// stage (m1). One address handshake per cycle; returns are routed back in
// issue order through the owner FIFO. m1 has priority, but m0 takes over
// after being blocked STARVE_LIMIT consecutive cycles.
module sram_arbiter
   import sram_arbiter_pkg::*;
#(
   parameter int DEPTH        = 4,
   parameter int STARVE_LIMIT = 8
) (
   input  logic                     clk,
   input  logic                     resetn,
   input  logic                     m0_req,
   input  logic                     m0_wr,
   input  logic [1:0]               m0_size,
   input  logic [31:0]              m0_addr,
   input  logic [3:0]               m0_wstrb,
   input  logic [31:0]              m0_wdata,
   output logic                     m0_addr_ok,
   output logic                     m0_data_ok,
   output logic [31:0]              m0_rdata,
   input  logic                     m1_req,
   input  logic                     m1_wr,
   input  logic [1:0]               m1_size,
   input  logic [31:0]              m1_addr,
   input  logic [3:0]               m1_wstrb,
   input  logic [31:0]              m1_wdata,
   output logic                     m1_addr_ok,
   output logic                     m1_data_ok,
   output logic [31:0]              m1_rdata,
   output logic                     s_req,
   output logic                     s_wr,
   output logic [1:0]               s_size,
   output logic [31:0]              s_addr,
   output logic [3:0]               s_wstrb,
   output logic [31:0]              s_wdata,
   input  logic                     s_addr_ok,
   input  logic                     s_data_ok,
   input  logic [31:0]              s_rdata,
   output logic [$clog2(DEPTH):0]   outstanding,
   output logic                     proto_err
);

   localparam int SW = $clog2(STARVE_LIMIT + 1);
   localparam logic [SW-1:0] STARVE_MAX = SW'(STARVE_LIMIT);
   localparam logic [SW-1:0] STARVE_ONE = SW'(1);

   logic          sel;
   logic          sel_req;
   logic          lock_valid;
   logic          lock_id;
   logic          lock_hold;
   logic          grant;
   logic          pop;
   logic          fifo_full;
   logic          fifo_empty;
   logic          fifo_head;
   logic [SW-1:0] starve_cnt;
   sram_payload_t m0_pl;
   sram_payload_t m1_pl;
   sram_payload_t sel_pl;

   assign lock_hold = lock_valid & ((lock_id == MST_DATA) ? m1_req : m0_req);

   // Pick the master that owns the bus this cycle: a pending lock first, then
   // a starved fetch, then data, then fetch.
   always_comb begin
      sel = MST_INST;
      if (lock_hold)                                 sel = lock_id;
      else if ((starve_cnt == STARVE_MAX) && m0_req) sel = MST_INST;
      else if (m1_req)                               sel = MST_DATA;
      else if (m0_req)                               sel = MST_INST;
   end

   assign m0_pl  = {m0_wr, m0_size, m0_addr, m0_wstrb, m0_wdata};
   assign m1_pl  = {m1_wr, m1_size, m1_addr, m1_wstrb, m1_wdata};
   assign sel_pl = (sel == MST_DATA) ? m1_pl : m0_pl;

   assign sel_req = (sel == MST_DATA) ? m1_req : m0_req;
   assign s_req   = sel_req & ~fifo_full & resetn;
   assign s_wr    = sel_pl.wr;
   assign s_size  = sel_pl.size;
   assign s_addr  = sel_pl.addr;
   assign s_wstrb = sel_pl.wstrb;
   assign s_wdata = sel_pl.wdata;

   assign grant      = s_req & s_addr_ok;
   assign m0_addr_ok = grant & (sel == MST_INST);
   assign m1_addr_ok = grant & (sel == MST_DATA);

   assign pop        = s_data_ok & ~fifo_empty;
   assign m0_data_ok = pop & (fifo_head == MST_INST);
   assign m1_data_ok = pop & (fifo_head == MST_DATA);
   assign m0_rdata   = s_rdata;
   assign m1_rdata   = s_rdata;

   arb_owner_fifo #(.DEPTH(DEPTH)) u_owner_fifo (
      .clk     (clk),
      .resetn  (resetn),
      .push    (grant),
      .push_id (sel),
      .pop     (pop),
      .count   (outstanding),
      .head    (fifo_head),
      .empty   (fifo_empty),
      .full    (fifo_full)
   );

   // Keep an unaccepted request pinned to its master so the payload seen by
   // the slave stays stable; release on handshake or when the master withdraws.
   always_ff @(posedge clk or negedge resetn) begin
      if (!resetn) begin
         lock_valid <= 1'b0;
         lock_id    <= MST_INST;
      end else if (grant) begin
         lock_valid <= 1'b0;
      end else if (s_req) begin
         lock_valid <= 1'b1;
         lock_id    <= sel;
      end else if (!lock_hold) begin
         lock_valid <= 1'b0;
      end
   end

   // Count consecutive cycles fetch loses to data; frozen while the FIFO is full.
   always_ff @(posedge clk or negedge resetn) begin
      if (!resetn) begin
         starve_cnt <= '0;
      end else if (!m0_req || (grant && (sel == MST_INST))) begin
         starve_cnt <= '0;
      end else if (!fifo_full && (sel == MST_DATA) && (starve_cnt != STARVE_MAX)) begin
         starve_cnt <= starve_cnt + STARVE_ONE;
      end
   end

   // Sticky flag for a return that has no outstanding request to belong to.
   always_ff @(posedge clk or negedge resetn) begin
      if (!resetn) proto_err <= 1'b0;
      else if (s_data_ok && fifo_empty) proto_err <= 1'b1;
   end

endmodule

// File: tb/tb_sram_arbiter.sv
// Directed bench for sram_arbiter. Each cycle's expected grant is hand
// computed; granted owners go into a queue that a negedge monitor pops
// whenever the arbiter presents a data_ok.
module tb_sram_arbiter;

   localparam logic [31:0] A0 = 32'h1000_0000;
   localparam logic [31:0] A1 = 32'h2000_0004;
   localparam logic [31:0] W0 = 32'hAAAA_0000;
   localparam logic [31:0] W1 = 32'hBBBB_1111;

   logic        clk = 1'b0;
   logic        resetn;
   logic        m0_req, m0_wr, m0_addr_ok, m0_data_ok;
   logic [1:0]  m0_size;
   logic [31:0] m0_addr, m0_wdata, m0_rdata;
   logic [3:0]  m0_wstrb;
   logic        m1_req, m1_wr, m1_addr_ok, m1_data_ok;
   logic [1:0]  m1_size;
   logic [31:0] m1_addr, m1_wdata, m1_rdata;
   logic [3:0]  m1_wstrb;
   logic        s_req, s_wr, s_addr_ok, s_data_ok;
   logic [1:0]  s_size;
   logic [31:0] s_addr, s_wdata, s_rdata;
   logic [3:0]  s_wstrb;
   logic [2:0]  outstanding;
   logic        proto_err;

   int   tests_run    = 0;
   int   tests_failed = 0;
   int   cyc          = 0;
   logic exp_q[$];
   logic exp_owner;

   sram_arbiter #(.DEPTH(4), .STARVE_LIMIT(8)) dut (
      .clk(clk), .resetn(resetn),
      .m0_req(m0_req), .m0_wr(m0_wr), .m0_size(m0_size), .m0_addr(m0_addr),
      .m0_wstrb(m0_wstrb), .m0_wdata(m0_wdata), .m0_addr_ok(m0_addr_ok),
      .m0_data_ok(m0_data_ok), .m0_rdata(m0_rdata),
      .m1_req(m1_req), .m1_wr(m1_wr), .m1_size(m1_size), .m1_addr(m1_addr),
      .m1_wstrb(m1_wstrb), .m1_wdata(m1_wdata), .m1_addr_ok(m1_addr_ok),
      .m1_data_ok(m1_data_ok), .m1_rdata(m1_rdata),
      .s_req(s_req), .s_wr(s_wr), .s_size(s_size), .s_addr(s_addr),
      .s_wstrb(s_wstrb), .s_wdata(s_wdata), .s_addr_ok(s_addr_ok),
      .s_data_ok(s_data_ok), .s_rdata(s_rdata),
      .outstanding(outstanding), .proto_err(proto_err)
   );

   always #5 clk = ~clk;

   task automatic check_val(input string name, input logic [31:0] act, input logic [31:0] exp);
      tests_run++;
      if (act !== exp) begin
         tests_failed++;
         $display("[TB] FAIL %s: got %h, expected %h", name, act, exp);
      end
   endtask

   // Drive one cycle of inputs just after the rising edge, then wait for the
   // falling edge so the combinational outputs have settled.
   task automatic apply_stimulus(input logic r0, input logic r1, input logic aok, input logic dok);
      @(posedge clk);
      #1;
      m0_req    = r0;
      m1_req    = r1;
      s_addr_ok = aok;
      s_data_ok = dok;
      cyc++;
      s_rdata   = 32'hD000_0000 + 32'(cyc);
      @(negedge clk);
   endtask

   // Compare this cycle's bus outputs against the hand-computed expectation and
   // record an expected owner for every expected grant.
   task automatic check_output(input string name, input logic e_req, input logic e_sel,
                               input logic e_grant, input logic e_dok, input logic [2:0] e_out);
      check_val({name, " s_req"}, 32'(s_req), 32'(e_req));
      check_val({name, " m0_addr_ok"}, 32'(m0_addr_ok), 32'(e_grant & ~e_sel));
      check_val({name, " m1_addr_ok"}, 32'(m1_addr_ok), 32'(e_grant & e_sel));
      check_val({name, " data_ok"}, 32'(m0_data_ok | m1_data_ok), 32'(e_dok));
      check_val({name, " outstanding"}, 32'(outstanding), 32'(e_out));
      if (e_req) begin
         check_val({name, " s_addr"}, s_addr, e_sel ? A1 : A0);
         check_val({name, " s_wdata"}, s_wdata, e_sel ? W1 : W0);
      end
      if (e_grant) exp_q.push_back(e_sel);
   endtask

   task automatic do_reset();
      @(posedge clk);
      #1;
      resetn    = 1'b0;
      m0_req    = 1'b0;
      m1_req    = 1'b0;
      s_addr_ok = 1'b0;
      s_data_ok = 1'b0;
      exp_q.delete();
      repeat (2) @(posedge clk);
      #1;
      resetn = 1'b1;
   endtask

   // Scoreboard monitor: every data_ok must match the oldest expected owner.
   always @(negedge clk) begin
      if (m0_data_ok || m1_data_ok) begin
         if (!resetn) begin
            tests_run++; tests_failed++;
            $display("[TB] FAIL data_ok_in_reset: got data_ok=1, expected 0");
         end else if (m0_data_ok && m1_data_ok) begin
            tests_run++; tests_failed++;
            $display("[TB] FAIL data_ok_both: got both data_ok, expected one");
         end else if (exp_q.size() == 0) begin
            tests_run++; tests_failed++;
            $display("[TB] FAIL data_ok_unexpected: got data_ok with no request pending, expected none");
         end else begin
            exp_owner = exp_q.pop_front();
            check_val("return owner", 32'(m1_data_ok), 32'(exp_owner));
            check_val("return rdata", m0_data_ok ? m0_rdata : m1_rdata, s_rdata);
         end
      end
   end

   initial begin
      resetn = 1'b0;
      m0_req = 1'b0; m0_wr = 1'b0; m0_size = 2'd2; m0_addr = A0; m0_wstrb = 4'hF; m0_wdata = W0;
      m1_req = 1'b0; m1_wr = 1'b1; m1_size = 2'd1; m1_addr = A1; m1_wstrb = 4'h3; m1_wdata = W1;
      s_addr_ok = 1'b0; s_data_ok = 1'b0; s_rdata = '0;

      // Test 1: reset in the middle of two outstanding requests, then a stray return.
      do_reset();
      apply_stimulus(1, 0, 1, 0); check_output("t1 c1", 1, 0, 1, 0, 0);
      apply_stimulus(1, 0, 1, 0); check_output("t1 c2", 1, 0, 1, 0, 1);
      apply_stimulus(1, 0, 0, 0); check_output("t1 c3", 1, 0, 0, 0, 2);
      #1;
      exp_q.delete();
      resetn = 1'b0; m0_req = 1'b1; s_addr_ok = 1'b1; s_data_ok = 1'b1;
      #1;
      check_val("t1 rst s_req", 32'(s_req), 0);
      check_val("t1 rst m0_addr_ok", 32'(m0_addr_ok), 0);
      check_val("t1 rst data_ok", 32'(m0_data_ok | m1_data_ok), 0);
      check_val("t1 rst outstanding", 32'(outstanding), 0);
      check_val("t1 rst proto_err", 32'(proto_err), 0);
      @(posedge clk);
      #1;
      resetn = 1'b1; m0_req = 1'b0; s_addr_ok = 1'b0; s_data_ok = 1'b0;
      apply_stimulus(0, 0, 0, 1); check_output("t1 stray", 0, 0, 0, 0, 0);
      check_val("t1 proto_err before", 32'(proto_err), 0);
      apply_stimulus(0, 0, 0, 0); check_output("t1 after", 0, 0, 0, 0, 0);
      check_val("t1 proto_err sticky", 32'(proto_err), 1);

      // Test 2: data side wins a tie; returns follow issue order.
      do_reset();
      check_val("t2 proto_err cleared", 32'(proto_err), 0);
      apply_stimulus(1, 1, 1, 0); check_output("t2 c1", 1, 1, 1, 0, 0);
      apply_stimulus(1, 0, 1, 0); check_output("t2 c2", 1, 0, 1, 0, 1);
      apply_stimulus(0, 0, 0, 1); check_output("t2 c3", 0, 0, 0, 1, 2);
      apply_stimulus(0, 0, 0, 1); check_output("t2 c4", 0, 0, 0, 1, 1);
      apply_stimulus(0, 0, 0, 0); check_output("t2 c5", 0, 0, 0, 0, 0);

      // Test 3: fetch blocked by continuous data traffic wins on the 9th cycle.
      do_reset();
      for (int k = 1; k <= 10; k++) begin
         apply_stimulus(1, 1, 1, k >= 2);
         check_output($sformatf("t3 c%0d", k), 1, k != 9, 1, k >= 2, (k == 1) ? 3'd0 : 3'd1);
      end
      apply_stimulus(0, 0, 0, 1); check_output("t3 drain", 0, 0, 0, 1, 1);
      apply_stimulus(0, 0, 0, 0); check_output("t3 idle", 0, 0, 0, 0, 0);

      // Test 4: lock holds payload while addr_ok is low; withdrawing releases it.
      do_reset();
      apply_stimulus(1, 0, 0, 0); check_output("t4 c1", 1, 0, 0, 0, 0);
      apply_stimulus(1, 0, 0, 0); check_output("t4 c2", 1, 0, 0, 0, 0);
      apply_stimulus(1, 0, 0, 0); check_output("t4 c3", 1, 0, 0, 0, 0);
      apply_stimulus(1, 1, 0, 0); check_output("t4 c4", 1, 0, 0, 0, 0);
      apply_stimulus(1, 1, 1, 0); check_output("t4 c5", 1, 0, 1, 0, 0);
      apply_stimulus(1, 0, 0, 0); check_output("t4 c6", 1, 0, 0, 0, 1);
      apply_stimulus(1, 1, 0, 0); check_output("t4 c7", 1, 0, 0, 0, 1);
      apply_stimulus(0, 1, 0, 0); check_output("t4 c8", 1, 1, 0, 0, 1);
      apply_stimulus(1, 1, 0, 0); check_output("t4 c9", 1, 1, 0, 0, 1);
      apply_stimulus(1, 1, 1, 0); check_output("t4 c10", 1, 1, 1, 0, 1);
      apply_stimulus(0, 0, 0, 1); check_output("t4 c11", 0, 0, 0, 1, 2);
      apply_stimulus(0, 0, 0, 1); check_output("t4 c12", 0, 0, 0, 1, 1);
      apply_stimulus(0, 0, 0, 0); check_output("t4 c13", 0, 0, 0, 0, 0);

      // Test 5: full FIFO blocks requests even when a return pops the same cycle.
      do_reset();
      for (int k = 1; k <= 4; k++) begin
         apply_stimulus(1, 0, 1, 0);
         check_output($sformatf("t5 fill%0d", k), 1, 0, 1, 0, 3'(k - 1));
      end
      apply_stimulus(1, 0, 1, 1); check_output("t5 full pop", 0, 0, 0, 1, 4);
      apply_stimulus(1, 0, 1, 0); check_output("t5 resume", 1, 0, 1, 0, 3);
      apply_stimulus(0, 0, 0, 0); check_output("t5 refull", 0, 0, 0, 0, 4);
      for (int k = 0; k < 4; k++) begin
         apply_stimulus(0, 0, 0, 1);
         check_output($sformatf("t5 drain%0d", k), 0, 0, 0, 1, 3'(4 - k));
      end
      apply_stimulus(0, 0, 0, 0); check_output("t5 idle", 0, 0, 0, 0, 0);

      // Test 6: alternating masters with a return every cycle, pointers wrap twice.
      do_reset();
      apply_stimulus(1, 0, 1, 0); check_output("t6 c1", 1, 0, 1, 0, 0);
      for (int k = 2; k <= 9; k++) begin
         apply_stimulus(k % 2 != 0, k % 2 == 0, 1, 1);
         check_output($sformatf("t6 c%0d", k), 1, k % 2 == 0, 1, 1, 1);
      end
      apply_stimulus(0, 0, 0, 1); check_output("t6 drain", 0, 0, 0, 1, 1);
      apply_stimulus(0, 0, 0, 0); check_output("t6 idle", 0, 0, 0, 0, 0);
      check_val("t6 proto_err", 32'(proto_err), 0);
      check_val("t6 queue empty", 32'(exp_q.size()), 0);

      $display("[TB] %0d tests run, %0d failed", tests_run, tests_failed);
      $finish;
   end

endmodule
